// File: rtl/localbus_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : localbus_dma_if
// Brief    : Control and local-bus signal bundle for localbus_dma.
// Revision : 1.0 - initial release
// ============================================================================
interface localbus_dma_if #(
    parameter int XLEN   = 32,
    parameter int LWIDTH = 16
);
    logic              start;
    logic              abort;
    logic [XLEN-1:0]   src;
    logic [XLEN-1:0]   dst;
    logic [LWIDTH-1:0] len;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic              bus_req;
    logic              bus_gnt;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [2:0]        bus_we;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        input  start, abort, src, dst, len, bus_gnt, bus_rdata,
        output busy, done, err, bus_req, bus_addr, bus_wdata, bus_we
    );

    modport slave (
        output start, abort, src, dst, len, bus_gnt, bus_rdata,
        input  busy, done, err, bus_req, bus_addr, bus_wdata, bus_we
    );
endinterface
`default_nettype wire

// File: rtl/localbus_dma.sv
`default_nettype none
// ============================================================================
// Module   : localbus_dma
// Brief    : Word-at-a-time local-bus copy engine (read src, write dst).
// Revision : 1.0 - initial release
// ============================================================================
module localbus_dma #(
    parameter int         XLEN       = 32,
    parameter int         LWIDTH     = 16,
    parameter int         RD_LATENCY = 1,      // legal range 1..3
    parameter logic [2:0] WE_WORD    = 3'b100
) (
    input  logic                 clk,
    input  logic                 rst,
    localbus_dma_if.master       dma
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_req     = 3'd1;
    localparam logic [2:0] c_rd_addr = 3'd2;
    localparam logic [2:0] c_rd_wait = 3'd3;
    localparam logic [2:0] c_wr      = 3'd4;
    localparam logic [2:0] c_done    = 3'd5;

    localparam logic [1:0] c_lat_last  = 2'(RD_LATENCY - 1);
    localparam logic [1:0] c_err_none  = 2'b00;
    localparam logic [1:0] c_err_align = 2'b01;
    localparam logic [1:0] c_err_abort = 2'b10;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [XLEN-1:0]   r_src;
    logic [XLEN-1:0]   r_dst;
    logic [XLEN-1:0]   r_data;
    logic [LWIDTH-1:0] r_rem;
    logic [1:0]        r_lat;
    logic [1:0]        r_err;

    logic w_misaligned;
    logic w_active;
    logic w_rd_phase;
    logic w_wr_phase;
    logic w_lat_done;

    assign w_misaligned = (|dma.src[1:0]) | (|dma.dst[1:0]);
    assign w_rd_phase   = (r_state == c_rd_addr) || (r_state == c_rd_wait);
    assign w_wr_phase   = (r_state == c_wr);
    assign w_active     = (r_state == c_req) || w_rd_phase || w_wr_phase;
    assign w_lat_done   = (r_lat == c_lat_last);

    // Bus outputs decode from state and registers only, and are zero when
    // not driving so several masters can be OR-ed onto the same bus.
    assign dma.bus_addr  = w_rd_phase ? r_src : (w_wr_phase ? r_dst : '0);
    assign dma.bus_wdata = w_wr_phase ? r_data : '0;
    assign dma.bus_we    = w_wr_phase ? WE_WORD : 3'b000;
    assign dma.bus_req   = w_active;
    assign dma.busy      = w_active;
    assign dma.done      = (r_state == c_done);
    assign dma.err       = (r_state == c_done) ? r_err : c_err_none;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (dma.start) begin
                    if (w_misaligned || (dma.len == '0)) begin
                        w_next = c_done;
                    end else begin
                        w_next = c_req;
                    end
                end
            end
            c_req: begin
                if (dma.abort)        w_next = c_done;
                else if (dma.bus_gnt) w_next = c_rd_addr;
            end
            c_rd_addr: begin
                w_next = dma.abort ? c_done : c_rd_wait;
            end
            c_rd_wait: begin
                if (dma.abort)        w_next = c_done;
                else if (w_lat_done)  w_next = c_wr;
            end
            c_wr: begin
                // Grant is only re-examined here, at a word boundary.
                if (dma.abort)                         w_next = c_done;
                else if (r_rem == LWIDTH'(1))          w_next = c_done;
                else if (dma.bus_gnt)                  w_next = c_rd_addr;
                else                                   w_next = c_req;
            end
            c_done:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_data <= '0;
            r_rem  <= '0;
            r_lat  <= '0;
            r_err  <= c_err_none;
        end else begin
            case (r_state)
                c_idle: begin
                    if (dma.start) begin
                        if (w_misaligned) begin
                            r_err <= c_err_align;
                        end else begin
                            r_err <= c_err_none;
                            if (dma.len != '0) begin
                                r_src <= dma.src;
                                r_dst <= dma.dst;
                                r_rem <= dma.len;
                            end
                        end
                    end
                end
                c_req: begin
                    if (dma.abort) r_err <= c_err_abort;
                end
                c_rd_addr: begin
                    r_lat <= '0;
                    if (dma.abort) r_err <= c_err_abort;
                end
                c_rd_wait: begin
                    if (dma.abort) begin
                        r_err <= c_err_abort;
                    end else if (w_lat_done) begin
                        r_data <= dma.bus_rdata;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                c_wr: begin
                    // An aborted write still reaches the bus but does not advance.
                    if (dma.abort) begin
                        r_err <= c_err_abort;
                    end else begin
                        r_src <= r_src + XLEN'(4);
                        r_dst <= r_dst + XLEN'(4);
                        r_rem <= r_rem - LWIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_localbus_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_localbus_dma
// Brief    : Directed self-checking bench for localbus_dma.
// Revision : 1.0 - initial release
// ============================================================================
module tb_localbus_dma;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_wr;
    int   n_req;
    int   n_act;
    int   s_wr;
    int   s_req;
    int   s_act;
    logic [31:0] mem [0:15];

    localbus_dma_if #(.XLEN(32), .LWIDTH(16)) bif ();

    localbus_dma #(
        .XLEN       (32),
        .LWIDTH     (16),
        .RD_LATENCY (1),
        .WE_WORD    (3'b100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dma (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: RAM at 0x1000..0x103F, answers combinationally on reads.
    always_comb begin
        bif.bus_rdata = '0;
        if (bif.bus_we == 3'b000 && bif.bus_addr[31:6] == 26'h40)
            bif.bus_rdata = mem[bif.bus_addr[5:2]];
    end

    always @(negedge clk) begin
        if (bif.bus_we != 3'b000) n_wr++;
        if (bif.bus_req) n_req++;
        if (bif.bus_we != 3'b000 || bif.bus_addr != '0 || bif.bus_wdata != '0) n_act++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller in cycle 1 (just after the edge that samples start).
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        bif.src   = s;
        bif.dst   = d;
        bif.len   = l;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
    endtask

    task automatic snap();
        s_wr  = n_wr;
        s_req = n_req;
        s_act = n_act;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; n_wr = 0; n_req = 0; n_act = 0;
        mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; mem[3] = 32'hD;
        for (int i = 4; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1;
        bif.start = 1'b0; bif.abort = 1'b0; bif.bus_gnt = 1'b0;
        bif.src = '0; bif.dst = '0; bif.len = '0;

        // Reset state
        tick(); tick();
        chk("rst_busy",  32'(bif.busy),    32'd0);
        chk("rst_done",  32'(bif.done),    32'd0);
        chk("rst_err",   32'(bif.err),     32'd0);
        chk("rst_req",   32'(bif.bus_req), 32'd0);
        chk("rst_addr",  bif.bus_addr,     32'd0);
        chk("rst_wdata", bif.bus_wdata,    32'd0);
        chk("rst_we",    32'(bif.bus_we),  32'd0);
        @(negedge clk) rst = 1'b0;

        // Three-word copy, grant held
        bif.bus_gnt = 1'b1;
        start_xfer(32'h1000, 32'h2000, 16'd3);
        chk("cp_c1_busy", 32'(bif.busy), 32'd1);
        chk("cp_c1_addr", bif.bus_addr, 32'd0);
        for (int c = 2; c <= 11; c++) begin
            tick();
            chk($sformatf("cp_we_c%0d", c), 32'(bif.bus_we),
                (c == 4 || c == 7 || c == 10) ? 32'd4 : 32'd0);
            chk($sformatf("cp_done_c%0d", c), 32'(bif.done), (c == 11) ? 32'd1 : 32'd0);
            if (c == 2)  chk("cp_rdaddr", bif.bus_addr, 32'h1000);
            if (c == 4)  begin chk("cp_wa0", bif.bus_addr, 32'h2000); chk("cp_wd0", bif.bus_wdata, 32'hA); end
            if (c == 7)  begin chk("cp_wa1", bif.bus_addr, 32'h2004); chk("cp_wd1", bif.bus_wdata, 32'hB); end
            if (c == 10) begin chk("cp_wa2", bif.bus_addr, 32'h2008); chk("cp_wd2", bif.bus_wdata, 32'hC); end
            if (c == 11) chk("cp_err", 32'(bif.err), 32'd0);
        end
        tick();
        chk("cp_idle_done", 32'(bif.done), 32'd0);

        // Zero length
        snap();
        start_xfer(32'h1000, 32'h2000, 16'd0);
        chk("len0_done", 32'(bif.done), 32'd1);
        chk("len0_err",  32'(bif.err),  32'd0);
        tick();
        chk("len0_noreq", 32'(n_req - s_req), 32'd0);

        // Misaligned source / destination
        snap();
        start_xfer(32'h1002, 32'h2000, 16'd2);
        chk("mis_src_done", 32'(bif.done), 32'd1);
        chk("mis_src_err",  32'(bif.err),  32'd1);
        tick();
        start_xfer(32'h1000, 32'h2001, 16'd0);
        chk("mis_dst_err",  32'(bif.err),  32'd1);
        tick();
        chk("mis_noreq", 32'(n_req - s_req), 32'd0);
        chk("mis_nobus", 32'(n_act - s_act), 32'd0);

        // Grant withheld for 5 cycles
        bif.bus_gnt = 1'b0;
        start_xfer(32'h1000, 32'h2000, 16'd1);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("gnt_req_c%0d", c), 32'(bif.bus_req), 32'd1);
            chk($sformatf("gnt_addr_c%0d", c), bif.bus_addr, 32'd0);
            chk($sformatf("gnt_we_c%0d", c), 32'(bif.bus_we), 32'd0);
            if (c < 5) tick();
        end
        @(negedge clk) bif.bus_gnt = 1'b1;
        tick();
        chk("gnt_rdaddr", bif.bus_addr, 32'h1000);
        tick(); tick();
        chk("gnt_we",    32'(bif.bus_we), 32'd4);
        chk("gnt_wdata", bif.bus_wdata,   32'hA);
        tick();
        chk("gnt_done",  32'(bif.done),   32'd1);

        // Destination wrap, with a start pulse ignored while busy
        tick();
        start_xfer(32'h1000, 32'hFFFF_FFFC, 16'd2);
        tick(); tick();
        chk("wrap_we0", 32'(bif.bus_we), 32'd0);
        @(negedge clk);
        bif.src = 32'h1008; bif.dst = 32'h4000; bif.len = 16'd5; bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        chk("wrap_wa0", bif.bus_addr,  32'hFFFF_FFFC);
        chk("wrap_wd0", bif.bus_wdata, 32'hA);
        tick(); tick(); tick();
        chk("wrap_wa1", bif.bus_addr,  32'h0000_0000);
        chk("wrap_we1", 32'(bif.bus_we), 32'd4);
        chk("wrap_wd1", bif.bus_wdata, 32'hB);
        tick();
        chk("wrap_done", 32'(bif.done), 32'd1);
        @(negedge clk) bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        chk("done_start_ignored", 32'(bif.busy), 32'd0);

        // Abort during RD_WAIT of word 2 of 4
        tick();
        snap();
        start_xfer(32'h1000, 32'h3000, 16'd4);
        for (int c = 2; c <= 6; c++) tick();
        chk("ab_rdwait_addr", bif.bus_addr, 32'h1004);
        @(negedge clk) bif.abort = 1'b1;
        tick();
        chk("ab_done", 32'(bif.done), 32'd1);
        chk("ab_err",  32'(bif.err),  32'd2);
        tick();
        bif.abort = 1'b0;
        chk("ab_idle", 32'(bif.busy), 32'd0);
        chk("ab_nwr",  32'(n_wr - s_wr), 32'd1);

        // Abort during WR still issues that write
        snap();
        start_xfer(32'h1000, 32'h3000, 16'd4);
        tick(); tick(); tick();
        @(negedge clk) bif.abort = 1'b1;
        chk("abwr_we", 32'(bif.bus_we), 32'd4);
        tick();
        chk("abwr_err", 32'(bif.err), 32'd2);
        bif.abort = 1'b0;
        tick();
        chk("abwr_nwr", 32'(n_wr - s_wr), 32'd1);

        // Reset mid-transfer, then a fresh transfer
        start_xfer(32'h1000, 32'h2000, 16'd3);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(bif.busy),   32'd0);
        chk("mrst_addr", bif.bus_addr,    32'd0);
        chk("mrst_we",   32'(bif.bus_we), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mrst_nodone_%0d", c), 32'(bif.done), 32'd0);
        end
        start_xfer(32'h1008, 32'h5000, 16'd1);
        tick(); tick(); tick();
        chk("post_wa", bif.bus_addr,  32'h5000);
        chk("post_wd", bif.bus_wdata, 32'hC);
        tick();
        chk("post_done", 32'(bif.done), 32'd1);
        chk("post_err",  32'(bif.err),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
